// File: rtl/sha1_padder.sv
// SHA-1 message front end: packs bytes big-endian into 512-bit blocks and appends
// the 0x80 marker, zero fill and the 64-bit message bit length.
module sha1_padder #(
    parameter int unsigned LEN_WIDTH = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_first,
    output logic         block_last,
    output logic         busy
);
    localparam int unsigned CntWidth = LEN_WIDTH - 3;

    typedef enum logic [2:0] {StCollect, StPad, StEmit, StPad2, StEmitLast} state_e;

    state_e                state_q, state_d;
    logic [511:0]          blk_q, blk_d;
    logic [5:0]            pos_q, pos_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  first_q, first_d;
    logic                  pad2_q, pad2_d;
    logic                  pend_q, pend_d;
    logic                  busy_q, busy_d;
    logic [8:0]            shamt;
    logic [63:0]           len_field;

    assign shamt     = {pos_q, 3'b000};
    assign len_field = 64'({count_q, 3'b000});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StCollect;
            blk_q   <= '0;
            pos_q   <= '0;
            count_q <= '0;
            first_q <= 1'b1;
            pad2_q  <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            pos_q   <= pos_d;
            count_q <= count_d;
            first_q <= first_d;
            pad2_q  <= pad2_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
        end
    end

    // The buffer is cleared after every handshake, so writes only need to OR bytes in.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        pos_d   = pos_q;
        count_d = count_q;
        first_d = first_q;
        pad2_d  = pad2_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        unique case (state_q)
            StCollect: begin
                if (in_valid) begin
                    blk_d   = blk_q | ({in_data, 504'b0} >> shamt);
                    pos_d   = pos_q + 6'd1;
                    count_d = count_q + CntWidth'(1);
                    busy_d  = 1'b1;
                    if (in_last) begin
                        state_d = StPad;
                    end else if (pos_q == 6'd63) begin
                        state_d = StEmit;
                    end
                end
            end
            StPad: begin
                // pos has wrapped to 0 only when the last byte filled the block.
                if (pos_q == 6'd0) begin
                    pad2_d  = 1'b1;
                    pend_d  = 1'b1;
                    state_d = StEmit;
                end else begin
                    blk_d = blk_q | ({8'h80, 504'b0} >> shamt);
                    if (pos_q <= 6'd55) begin
                        blk_d[63:0] = len_field;
                        state_d     = StEmitLast;
                    end else begin
                        pad2_d  = 1'b1;
                        pend_d  = 1'b0;
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                if (block_ready) begin
                    blk_d   = '0;
                    pos_d   = '0;
                    first_d = 1'b0;
                    state_d = pad2_q ? StPad2 : StCollect;
                end
            end
            StPad2: begin
                blk_d = '0;
                if (pend_q) begin
                    blk_d[511:504] = 8'h80;
                end
                blk_d[63:0] = len_field;
                pad2_d      = 1'b0;
                pend_d      = 1'b0;
                state_d     = StEmitLast;
            end
            StEmitLast: begin
                if (block_ready) begin
                    blk_d   = '0;
                    pos_d   = '0;
                    count_d = '0;
                    first_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    assign in_ready    = (state_q == StCollect) && !reset;
    assign block_valid = (state_q == StEmit) || (state_q == StEmitLast);
    assign block_last  = (state_q == StEmitLast);
    assign block_first = first_q;
    assign block_out   = blk_q;
    assign busy        = busy_q;

endmodule
